vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates the raster counters and sync signals for the 640x480@60 display path. The downstream display-ready logic and pixel pipeline consume these counters. The block produces registered hcount/vcount, hsync/vsync, an active-video flag, pixel coordinates, and line/frame start strobes. All timing advances on a pixel-clock enable, so the block runs from the system clock.

Parameters:
H_SYNC, 96, hsync pulse width in pixels
H_BACK, 48, horizontal back porch in pixels
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch in pixels
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch in lines
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch in lines
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  pixel tick; timing advances only on cycles with en=1
hcount  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL=800)
vcount  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL=525)
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
active  out  1  1 while the pixel is inside the visible window
posx  out  10  visible column 0..639; 0 outside the window
posy  out  10  visible row 0..479; 0 outside the window
line_start  out  1  one-clk strobe when hcount wraps to 0
frame_start  out  1  one-clk strobe when hcount and vcount both wrap to 0

Behaviour:
- Reset (async assert, sync release): hcount=0, vcount=0, hsync=vsync=SYNC_POL, active=0, posx=0, posy=0, line_start=0, frame_start=0. Counter 0 lies inside the sync pulse, so sync is asserted out of reset.
- All outputs are registered. They are computed from the next-state counter values, so hsync/vsync/active/posx/posy always correspond to the hcount/vcount presented in the same cycle, with zero skew.
- en=1:
  - hcount increments; at 799 it wraps to 0 and vcount advances.
  - vcount wraps from 524 to 0.
- en=0: counters and level outputs hold; line_start and frame_start are 0.
- Horizontal phase FSM (advances on en): SYNC (hcount 0..95) -> BACK (96..143) -> ACTIVE (144..783) -> FRONT (784..799) -> SYNC. The vertical FSM uses the same states (vcount 0..1, 2..34, 35..514, 515..524) and advances only on the hcount wrap.
- hsync = SYNC_POL iff hcount in 0..95; vsync = SYNC_POL iff vcount in 0..1.
- active=1 iff hcount in 144..783 and vcount in 35..514.
- posx = hcount-144 when the horizontal phase is ACTIVE, else 0. posy = vcount-35 when the vertical phase is ACTIVE, else 0. Subtraction is 10-bit unsigned and never underflows inside ACTIVE.
- line_start=1 for exactly the clk cycle in which hcount becomes 0 via wrap, not via reset.
- frame_start=1 coincides with a line_start in which vcount also becomes 0.
- Phase boundaries derive from parameters (H_TOTAL = sum of the H_* parameters, likewise V_TOTAL). Counter width is fixed at 10 bits; H_TOTAL and V_TOTAL must be <= 1024.
- Reset mid-frame: all outputs return to reset values immediately. After release, counting restarts from 0,0 on the next en, with no strobe issued.

Decomposition:
- Package vga_timing_pkg holds:
  - the phase enum (SYNC, BACK, ACTIVE, FRONT);
  - default 640x480 timing constants;
  - derived H_TOTAL, V_TOTAL, H_ACT_START, V_ACT_START.
- Sub-module vga_axis_counter holds one counter plus its phase FSM, a wrap output and an advance input. It is instantiated twice: horizontal with advance=en, and vertical with advance=en & hwrap.

Test Plan:
- Reset, then 144 en cycles -> hsync low for hcount 0..95 and high from 96; active=0 throughout, because vcount=0 is in vertical sync.
- Run to vcount=35, hcount=144 -> active=1, posx=0, posy=0. At hcount=783: posx=639. At hcount=784: active=0, posx=0.
- Hold en=0 for 10 clks mid-line at hcount=500 -> all outputs frozen and no strobes. On the next en, hcount=501.
- Run from reset across hcount 799->0 -> line_start high one clk, vcount=1, frame_start=0.
- Run 420000 en cycles from reset -> hcount=0, vcount=0 with frame_start=line_start=1 for one clk. vsync is asserted for exactly 1600 en cycles per frame, and active is high for exactly 307200 en cycles per frame.
- Assert rst at vcount=200, hcount=300 for 3 clks -> outputs at reset values during rst. After release, counting resumes from 0 with no spurious strobe.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: raster phase type and default 640x480@60 timing constants.
package vga_timing_pkg;
    typedef enum logic [1:0] {SYNC, BACK, ACTIVE, FRONT} phase_t;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int H_TOTAL      = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int V_TOTAL      = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;
    localparam int H_ACT_START  = DEF_H_SYNC + DEF_H_BACK;
    localparam int V_ACT_START  = DEF_V_SYNC + DEF_V_BACK;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter with its sync/back/active/front phase FSM.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter int BACK_LEN   = DEF_H_BACK,
    parameter int ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int FRONT_LEN  = DEF_H_FRONT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [9:0] count,
    output logic [9:0] count_nxt,
    output phase_t     phase_nxt,
    output logic       wrap
);
    localparam logic [9:0] LAST     = 10'(SYNC_LEN + BACK_LEN + ACTIVE_LEN + FRONT_LEN - 1);
    localparam logic [9:0] SYNC_END = 10'(SYNC_LEN - 1);
    localparam logic [9:0] BACK_END = 10'(SYNC_LEN + BACK_LEN - 1);
    localparam logic [9:0] ACT_END  = 10'(SYNC_LEN + BACK_LEN + ACTIVE_LEN - 1);
    phase_t phase;
    // Next-state values are exported so the parent can register outputs with zero skew.
    always_comb begin
        wrap      = adv && count == LAST;
        count_nxt = !adv ? count : wrap ? '0 : count + 10'd1;
        phase_nxt = !adv ? phase :
                    wrap ? SYNC :
                    count == SYNC_END ? BACK :
                    count == BACK_END ? ACTIVE :
                    count == ACT_END ? FRONT : phase;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            count <= '0;
            phase <= SYNC;
        end else begin
            count <= count_nxt;
            phase <= phase_nxt;
        end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, syncs, visible window and line/frame strobes,
// advancing on a pixel-clock enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       line_start,
    output logic       frame_start
);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    logic [9:0] h_nxt, v_nxt;
    phase_t     h_ph_nxt, v_ph_nxt;
    logic       h_wrap, v_wrap;

    vga_axis_counter #(
        .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK), .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT)
    ) u_h (
        .clk(clk), .rst(rst), .adv(en), .count(hcount), .count_nxt(h_nxt),
        .phase_nxt(h_ph_nxt), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK), .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT)
    ) u_v (
        .clk(clk), .rst(rst), .adv(en & h_wrap), .count(vcount), .count_nxt(v_nxt),
        .phase_nxt(v_ph_nxt), .wrap(v_wrap)
    );

    // v_wrap can only fire together with h_wrap, so it is the frame strobe directly.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hsync       <= SYNC_POL;
            vsync       <= SYNC_POL;
            active      <= 1'b0;
            posx        <= '0;
            posy        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (h_ph_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_ph_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
            active      <= h_ph_nxt == ACTIVE && v_ph_nxt == ACTIVE;
            posx        <= (h_ph_nxt == ACTIVE) ? h_nxt - H_START : '0;
            posy        <= (v_ph_nxt == ACTIVE) ? v_nxt - V_START : '0;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size 640x480 instance plus a reduced-timing, active-high-sync
// instance whose whole frame fits in a short run; both checked against an arithmetic model.
module tb_vga_timing_gen;
    localparam int SH = 12, SB = 6, SA = 40, SF = 4;
    localparam int SVS = 2, SVB = 3, SVA = 20, SVF = 2;
    localparam int SHT = SH + SB + SA + SF;
    localparam int SVT = SVS + SVB + SVA + SVF;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic [9:0] hc_d, vc_d, px_d, py_d, hc_s, vc_s, px_s, py_s;
    logic hs_d, vs_d, ac_d, ls_d, fs_d, hs_s, vs_s, ac_s, ls_s, fs_s;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .en(en), .hcount(hc_d), .vcount(vc_d), .hsync(hs_d),
        .vsync(vs_d), .active(ac_d), .posx(px_d), .posy(py_d), .line_start(ls_d),
        .frame_start(fs_d)
    );

    vga_timing_gen #(
        .H_SYNC(SH), .H_BACK(SB), .H_ACTIVE(SA), .H_FRONT(SF),
        .V_SYNC(SVS), .V_BACK(SVB), .V_ACTIVE(SVA), .V_FRONT(SVF), .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .hcount(hc_s), .vcount(vc_s), .hsync(hs_s),
        .vsync(vs_s), .active(ac_s), .posx(px_s), .posy(py_s), .line_start(ls_s),
        .frame_start(fs_s)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int hd = 0, vd = 0, hm = 0, vm = 0;
    bit lsd = 0, fsd = 0, lsm = 0, fsm = 0;
    int vs_cnt = 0, act_cnt = 0;

    function automatic logic [44:0] model(int h, int v, bit ls, bit fs, int HS, int HB,
                                          int HA, int VS, int VB, int VA, bit pol);
        bit ha = h >= HS + HB && h < HS + HB + HA;
        bit va = v >= VS + VB && v < VS + VB + VA;
        logic [9:0] px = ha ? 10'(h - HS - HB) : 10'd0;
        logic [9:0] py = va ? 10'(v - VS - VB) : 10'd0;
        return {10'(h), 10'(v), px, py, (h < HS) ? pol : !pol, (v < VS) ? pol : !pol,
                ha && va, ls, fs};
    endfunction

    function automatic logic [44:0] exp_d();
        return model(hd, vd, lsd, fsd, 96, 48, 640, 2, 33, 480, 1'b0);
    endfunction

    function automatic logic [44:0] exp_s();
        return model(hm, vm, lsm, fsm, SH, SB, SA, SVS, SVB, SVA, 1'b1);
    endfunction

    function automatic logic [44:0] got_d();
        return {hc_d, vc_d, px_d, py_d, hs_d, vs_d, ac_d, ls_d, fs_d};
    endfunction

    function automatic logic [44:0] got_s();
        return {hc_s, vc_s, px_s, py_s, hs_s, vs_s, ac_s, ls_s, fs_s};
    endfunction

    task automatic model_zero();
        hd = 0; vd = 0; hm = 0; vm = 0;
        lsd = 0; fsd = 0; lsm = 0; fsm = 0;
    endtask

    task automatic step(input bit e);
        en = e;
        @(posedge clk);
        #1;
        if (e) begin
            lsd = hd == 799;
            fsd = lsd && vd == 524;
            hd = lsd ? 0 : hd + 1;
            if (lsd) vd = fsd ? 0 : vd + 1;
            lsm = hm == SHT - 1;
            fsm = lsm && vm == SVT - 1;
            hm = lsm ? 0 : hm + 1;
            if (lsm) vm = fsm ? 0 : vm + 1;
            if (vs_s === 1'b1) vs_cnt++;
            if (ac_s === 1'b1) act_cnt++;
        end else begin
            lsd = 0; fsd = 0; lsm = 0; fsm = 0;
        end
    endtask

    task automatic test_reset();
        en = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_zero();
        checks++;
        if (got_d() !== exp_d()) begin
            errors++;
            $display("FAIL reset_d got %h expected %h", got_d(), exp_d());
        end
        checks++;
        if (got_s() !== exp_s()) begin
            errors++;
            $display("FAIL reset_s got %h expected %h", got_s(), exp_s());
        end
        rst = 0;
    endtask

    task automatic test_first_line();
        for (int i = 1; i <= 144; i++) begin
            step(1);
            checks++;
            if (hc_d !== 10'(i) || hs_d !== (i >= 96) || ac_d !== 1'b0) begin
                errors++;
                $display("FAIL first_line h=%0d got hc=%0d hs=%b act=%b expected hs=%b act=0",
                         i, hc_d, hs_d, ac_d, i >= 96);
            end
        end
    endtask

    task automatic test_hold();
        logic [44:0] frozen_d, frozen_s;
        for (int i = 0; i < 1000 && hd != 500; i++) step(1);
        checks++;
        if (hc_d !== 10'd500) begin
            errors++;
            $display("FAIL hold_reach got hc=%0d expected 500", hc_d);
        end
        frozen_d = exp_d();
        frozen_s = exp_s();
        for (int i = 0; i < 10; i++) begin
            step(0);
            checks++;
            if (got_d() !== {frozen_d[44:2], 2'b00} || got_s() !== {frozen_s[44:2], 2'b00}) begin
                errors++;
                $display("FAIL hold got %h/%h expected %h/%h", got_d(), got_s(),
                         {frozen_d[44:2], 2'b00}, {frozen_s[44:2], 2'b00});
            end
        end
        step(1);
        checks++;
        if (hc_d !== 10'd501) begin
            errors++;
            $display("FAIL hold_resume got hc=%0d expected 501", hc_d);
        end
    endtask

    task automatic test_line_wrap();
        for (int i = 0; i < 1000 && hd != 799; i++) step(1);
        step(1);
        checks++;
        if (hc_d !== 10'd0 || vc_d !== 10'd1 || ls_d !== 1'b1 || fs_d !== 1'b0) begin
            errors++;
            $display("FAIL line_wrap got hc=%0d vc=%0d ls=%b fs=%b expected 0 1 1 0",
                     hc_d, vc_d, ls_d, fs_d);
        end
        step(1);
        checks++;
        if (ls_d !== 1'b0 || hc_d !== 10'd1) begin
            errors++;
            $display("FAIL line_strobe_len got ls=%b hc=%0d expected 0 1", ls_d, hc_d);
        end
    endtask

    task automatic test_active_window();
        for (int i = 0; i < 30000 && !(vd == 35 && hd == 144); i++) step(1);
        checks++;
        if (hc_d !== 10'd144 || vc_d !== 10'd35 || ac_d !== 1'b1 || px_d !== 10'd0 || py_d !== 10'd0) begin
            errors++;
            $display("FAIL win_start got hc=%0d vc=%0d act=%b px=%0d py=%0d expected 144 35 1 0 0",
                     hc_d, vc_d, ac_d, px_d, py_d);
        end
        for (int i = 0; i < 1000 && hd != 783; i++) step(1);
        checks++;
        if (ac_d !== 1'b1 || px_d !== 10'd639 || py_d !== 10'd0) begin
            errors++;
            $display("FAIL win_end got act=%b px=%0d py=%0d expected 1 639 0", ac_d, px_d, py_d);
        end
        step(1);
        checks++;
        if (hc_d !== 10'd784 || ac_d !== 1'b0 || px_d !== 10'd0) begin
            errors++;
            $display("FAIL win_exit got hc=%0d act=%b px=%0d expected 784 0 0", hc_d, ac_d, px_d);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) != 0);
            checks++;
            if (got_d() !== exp_d() || got_s() !== exp_s()) begin
                errors++;
                $display("FAIL random cycle %0d got %h/%h expected %h/%h",
                         i, got_d(), got_s(), exp_d(), exp_s());
            end
        end
    endtask

    task automatic test_frame();
        rst = 1;
        #2;
        rst = 0;
        model_zero();
        vs_cnt = 0;
        act_cnt = 0;
        for (int i = 0; i < SHT * SVT; i++) step(1);
        checks++;
        if (hc_s !== 10'd0 || vc_s !== 10'd0 || ls_s !== 1'b1 || fs_s !== 1'b1) begin
            errors++;
            $display("FAIL frame_wrap got hc=%0d vc=%0d ls=%b fs=%b expected 0 0 1 1",
                     hc_s, vc_s, ls_s, fs_s);
        end
        checks++;
        if (vs_cnt != SVS * SHT) begin
            errors++;
            $display("FAIL vsync_count got %0d expected %0d", vs_cnt, SVS * SHT);
        end
        checks++;
        if (act_cnt != SA * SVA) begin
            errors++;
            $display("FAIL active_count got %0d expected %0d", act_cnt, SA * SVA);
        end
        step(1);
        checks++;
        if (ls_s !== 1'b0 || fs_s !== 1'b0 || got_s() !== exp_s()) begin
            errors++;
            $display("FAIL frame_after got %h expected %h", got_s(), exp_s());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4000 && !(vm == 10 && hm == 30); i++) step(1);
        checks++;
        if (vc_s !== 10'd10 || hc_s !== 10'd30) begin
            errors++;
            $display("FAIL mid_reach got vc=%0d hc=%0d expected 10 30", vc_s, hc_s);
        end
        rst = 1;
        #1;
        model_zero();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_d() !== exp_d() || got_s() !== exp_s()) begin
                errors++;
                $display("FAIL mid_reset clk %0d got %h/%h expected %h/%h",
                         i, got_d(), got_s(), exp_d(), exp_s());
            end
            @(posedge clk);
            #1;
        end
        rst = 0;
        step(0);
        step(1);
        checks++;
        if (got_d() !== exp_d() || got_s() !== exp_s() || hc_d !== 10'd1 || ls_s !== 1'b0) begin
            errors++;
            $display("FAIL mid_resume got %h/%h expected %h/%h", got_d(), got_s(), exp_d(), exp_s());
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_hold();
        test_line_wrap();
        test_active_window();
        test_random();
        test_frame();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
